// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch controller.
// Optional fetch timeout is enabled by FETCH_CTRL_TIMEOUT_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] INSN_BYTES     = 32'd4;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
  localparam logic [7:0]  TMO_LIMIT      = 8'd255;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory level-request port.
// master = fetch side, slave = memory side.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata
  );

endinterface

// File: rtl/fetch_redirect_mux.sv
// fetch_redirect_mux: prioritised redirect select.
// exc beats jump, jump beats taken branch.
module fetch_redirect_mux
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        exc_i,
  input  logic        jump_i,
  input  logic        branch_taken_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] branch_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  // highest-priority request wins the target
  always_comb begin
    redirect_o = 1'b1;
    target_o   = '0;
    if (exc_i) begin
      target_o = EXC_VECTOR;
    end else if (jump_i) begin
      target_o = jump_target_i;
    end else if (branch_taken_i) begin
      target_o = branch_target_i;
    end else begin
      redirect_o = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing and instruction fetch handshake.
// FETCH_CTRL_TIMEOUT_EN adds a 255-cycle ack timeout with retry.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_write,
  output logic [31:0] next_pc,
  input  logic        stall,
  input  logic        exc,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  fetch_if.master     imem,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        outst_q, outst_d;
  logic        vld_q, vld_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;

  logic        mux_redir;
  logic [31:0] target;
  logic        redir;
  logic        gap;
  logic        req_c;
  logic        blocked;
  logic        acc;

  fetch_redirect_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_mux (
    .exc_i           (exc),
    .jump_i          (jump),
    .branch_taken_i  (branch_taken),
    .jump_target_i   (jump_target),
    .branch_target_i (branch_target),
    .redirect_o      (mux_redir),
    .target_o        (target)
  );

  assign redir = mux_redir & (state_q != BOOT);

`ifdef FETCH_CTRL_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign gap       = (cnt_q == TMO_LIMIT);
  assign fetch_err = gap;
  assign cnt_d     = (req_c & ~imem.imem_ack) ?
                     cnt_q + 8'd1 : '0;

  // unacknowledged request cycle counter
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign gap       = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // next state, PC update and fetch handshake
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    drop_d   = drop_q;
    vld_d    = vld_q & stall;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    pc_write = 1'b0;
    next_pc  = pc;
    req_c    = 1'b0;
    blocked  = 1'b0;
    acc      = 1'b0;
    if (state_q == BOOT) begin
      pc_write = 1'b1;
      next_pc  = RESET_PC;
      addr_d   = RESET_PC;
      state_d  = FETCH;
    end else begin
      blocked = vld_q & stall;
      // a request already on the bus must be held
      req_c = ~gap & ~(blocked & ~outst_q);
      acc   = req_c & imem.imem_ack;
      if (acc) begin
        if (drop_q | redir) begin
          drop_d = 1'b0;
          addr_d = redir ? target : pc;
        end else if (!blocked) begin
          vld_d    = 1'b1;
          inst_d   = imem.imem_rdata;
          ipc_d    = addr_q;
          pc_write = 1'b1;
          next_pc  = pc + INSN_BYTES;
          addr_d   = pc + INSN_BYTES;
        end
      end else if (redir) begin
        if (req_c) drop_d = 1'b1;
        else       addr_d = target;
      end
      if (redir) begin
        pc_write = 1'b1;
        next_pc  = target;
        vld_d    = 1'b0;
      end
      state_d = (blocked & ~redir & ~(req_c & ~acc)) ?
                HOLD : FETCH;
    end
    if (reset) begin
      pc_write = 1'b0;
      req_c    = 1'b0;
    end
    outst_d = req_c & ~imem.imem_ack;
  end

  // state and fetch pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      outst_q <= 1'b0;
      vld_q   <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      outst_q <= outst_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = addr_q;
  assign inst_valid     = vld_q;
  assign inst           = inst_q;
  assign inst_pc        = ipc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector bench for fetch_ctrl.
// Timeout checks follow FETCH_CTRL_TIMEOUT_EN.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  typedef struct {
    logic        stall;
    logic        exc;
    logic        jump;
    logic        br;
    logic [31:0] jt;
    logic [31:0] bt;
    logic        pcw;
    logic [31:0] npc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_q;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        stall = 1'b0;
  logic        exc = 1'b0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] branch_target = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;

  int   lat = 0;
  logic mem_en = 1'b1;
  int   wcnt;
  int   checks = 0;
  int   errs = 0;
  vec_t tbl [15];

  fetch_if imem ();

  fetch_ctrl #(
    .RESET_PC (32'h0000_1000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc_q),
    .pc_write      (pc_write),
    .next_pc       (next_pc),
    .stall         (stall),
    .exc           (exc),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .imem          (imem.master),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset)         pc_q <= '0;
    else if (pc_write) pc_q <= next_pc;
  end

  always_ff @(posedge clk) begin
    if (!imem.imem_req || imem.imem_ack) wcnt <= 0;
    else                                 wcnt <= wcnt + 1;
  end

  assign imem.imem_ack = mem_en && imem.imem_req &&
                         (wcnt >= lat);
  assign imem.imem_rdata = imem.imem_addr ^ 32'h5A5A_0000;

  function automatic vec_t V(
    input logic s, e, j, b,
    input logic [31:0] jt, bt,
    input logic pw, input logic [31:0] np,
    input logic rq, input logic [31:0] ad,
    input logic vl, input logic [31:0] ip, ins
  );
    vec_t v;
    v.stall = s;  v.exc = e;  v.jump = j;  v.br = b;
    v.jt = jt;    v.bt = bt;  v.pcw = pw;  v.npc = np;
    v.req = rq;   v.addr = ad; v.vld = vl;
    v.ipc = ip;   v.inst = ins;
    return v;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic run(input string tag, input int l,
                     input vec_t v);
    @(negedge clk);
    lat = l;
    reset = 1'b0;
    stall = v.stall;
    exc = v.exc;
    jump = v.jump;
    branch_taken = v.br;
    jump_target = v.jt;
    branch_target = v.bt;
    #1;
    chk({tag, ".pcw"}, {31'd0, pc_write}, {31'd0, v.pcw});
    if (v.pcw) chk({tag, ".npc"}, next_pc, v.npc);
    chk({tag, ".req"}, {31'd0, imem.imem_req},
        {31'd0, v.req});
    chk({tag, ".addr"}, imem.imem_addr, v.addr);
    chk({tag, ".vld"}, {31'd0, inst_valid}, {31'd0, v.vld});
    if (v.vld) begin
      chk({tag, ".ipc"}, inst_pc, v.ipc);
      chk({tag, ".inst"}, inst, v.inst);
    end
    chk({tag, ".ferr"}, {31'd0, fetch_err}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    stall = 1'b0;
    exc = 1'b0;
    jump = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, ".pcw"}, {31'd0, pc_write}, 32'd0);
    chk({tag, ".req"}, {31'd0, imem.imem_req}, 32'd0);
    chk({tag, ".vld"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, ".inst"}, inst, 32'd0);
    chk({tag, ".ipc"}, inst_pc, 32'd0);
    chk({tag, ".ferr"}, {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int   nreq;
    logic seen;

    tbl[0]  = V(0,0,0,0, 0,0, 1,32'h1000, 0,32'h0000,
                0,0,0);
    tbl[1]  = V(0,0,0,0, 0,0, 1,32'h1004, 1,32'h1000,
                0,0,0);
    tbl[2]  = V(0,0,0,0, 0,0, 1,32'h1008, 1,32'h1004,
                1,32'h1000,32'h5A5A1000);
    tbl[3]  = V(0,0,0,0, 0,0, 1,32'h100C, 1,32'h1008,
                1,32'h1004,32'h5A5A1004);
    tbl[4]  = V(1,0,0,0, 0,0, 0,0, 0,32'h100C,
                1,32'h1008,32'h5A5A1008);
    tbl[5]  = V(1,0,0,0, 0,0, 0,0, 0,32'h100C,
                1,32'h1008,32'h5A5A1008);
    tbl[6]  = V(1,0,0,0, 0,0, 0,0, 0,32'h100C,
                1,32'h1008,32'h5A5A1008);
    tbl[7]  = V(0,0,0,0, 0,0, 1,32'h1010, 1,32'h100C,
                1,32'h1008,32'h5A5A1008);
    tbl[8]  = V(1,1,1,1, 32'h3000,32'h4000, 1,32'h0080,
                0,32'h1010, 1,32'h100C,32'h5A5A100C);
    tbl[9]  = V(0,0,0,0, 0,0, 1,32'h0084, 1,32'h0080,
                0,0,0);
    tbl[10] = V(0,0,1,0, 32'h3000,0, 1,32'h3000,
                1,32'h0084, 1,32'h0080,32'h5A5A0080);
    tbl[11] = V(0,0,1,1, 32'h5000,32'h6000, 1,32'h5000,
                1,32'h3000, 0,0,0);
    tbl[12] = V(0,0,0,1, 0,32'h6000, 1,32'h6000,
                1,32'h5000, 0,0,0);
    tbl[13] = V(0,0,0,0, 0,0, 1,32'h6004, 1,32'h6000,
                0,0,0);
    tbl[14] = V(0,0,0,0, 0,0, 1,32'h6008, 1,32'h6004,
                1,32'h6000,32'h5A5A6000);

    do_reset("rst0");
    for (int i = 0; i < 15; i++)
      run($sformatf("row%0d", i), 0, tbl[i]);

    // ack after 4 request cycles, branch in cycle 2
    run("dly1", 3, V(0,0,0,0, 0,0, 0,0, 1,32'h6008,
                     1,32'h6004,32'h5A5A6004));
    run("dly2", 3, V(0,0,0,1, 0,32'h2000, 1,32'h2000,
                     1,32'h6008, 0,0,0));
    run("dly3", 3, V(0,0,0,0, 0,0, 0,0, 1,32'h6008,
                     0,0,0));
    run("dly4", 3, V(0,0,0,0, 0,0, 0,0, 1,32'h6008,
                     0,0,0));
    run("dly5", 0, V(0,0,0,0, 0,0, 1,32'h2004, 1,32'h2000,
                     0,0,0));
    run("dly6", 0, V(0,0,0,0, 0,0, 1,32'h2008, 1,32'h2004,
                     1,32'h2000,32'h5A5A2000));

    // PC wrap at the top of the address space
    run("wrp1", 0, V(0,0,1,0, 32'hFFFF_FFFC,0,
                     1,32'hFFFF_FFFC, 1,32'h2008,
                     1,32'h2004,32'h5A5A2004));
    run("wrp2", 0, V(0,0,0,0, 0,0, 1,32'h0000_0000,
                     1,32'hFFFF_FFFC, 0,0,0));
    run("wrp3", 0, V(0,0,0,0, 0,0, 1,32'h0000_0004,
                     1,32'h0000_0000,
                     1,32'hFFFF_FFFC,32'hA5A5FFFC));

    // reset while a request waits for ack
    run("mid1", 3, V(0,0,0,0, 0,0, 0,0, 1,32'h0004,
                     1,32'h0000,32'h5A5A0000));
    do_reset("rst1");
    run("boot", 0, V(0,0,0,0, 0,0, 1,32'h1000, 0,32'h0000,
                     0,0,0));
    run("aft1", 0, V(0,0,0,0, 0,0, 1,32'h1004, 1,32'h1000,
                     0,0,0));

    // memory that never acknowledges
    nreq = 0;
    seen = 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
    for (int k = 0; k < 400; k++) begin
`else
    for (int k = 0; k < 300; k++) begin
`endif
      @(negedge clk);
      mem_en = 1'b0;
      #1;
      if (fetch_err) begin
        seen = 1'b1;
        break;
      end
      if (imem.imem_req) nreq++;
    end
`ifdef FETCH_CTRL_TIMEOUT_EN
    chk("tmo.seen", {31'd0, seen}, 32'd1);
    chk("tmo.nreq", nreq, 32'd255);
    chk("tmo.gapreq", {31'd0, imem.imem_req}, 32'd0);
    chk("tmo.gapaddr", imem.imem_addr, 32'h1004);
    @(negedge clk);
    #1;
    chk("tmo.rereq", {31'd0, imem.imem_req}, 32'd1);
    chk("tmo.readdr", imem.imem_addr, 32'h1004);
    chk("tmo.ferr0", {31'd0, fetch_err}, 32'd0);
`else
    chk("wait.seen", {31'd0, seen}, 32'd0);
    chk("wait.nreq", nreq, 32'd300);
    chk("wait.addr", imem.imem_addr, 32'h1004);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
